// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state encoding, frame width and common scan codes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam int PS2_DATA_BITS = 8;

  // Scan-code prefixes used by the keyboard MMIO consumer
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

  // True when data plus parity carries an odd number of ones
  function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                             input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO. Storage array with a registered head word; a push into
// the slot that becomes the head is bypassed so data_valid and head appear together.
module ps2_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when a pop frees a slot in the same cycle
  assign push_ok = push && (!full || pop_ok);

  assign rd_ptr_next = rd_ptr_reg + AW'(pop_ok);

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_reg + CW'(push_ok) - CW'(pop_ok);
      // Head slot being written this cycle: forward the incoming byte
      if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
        head_reg <= push_data;
      end else begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign head  = empty ? '0 : head_reg;
  assign count = count_reg;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, clock deglitch filter, frame FSM, sticky
// error flags and a FWFT byte FIFO. Define PS2_RX_PARITY_CHECK_EN to enforce odd parity.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          err_clr
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   clk_s;
  logic                   data_s;

  logic                   filt_reg;
  logic [FW-1:0]          filt_cnt_reg;
  logic                   edge_reg;

  ps2_rx_state_t          state_reg, state_next;
  logic [2:0]             bit_idx_reg, bit_idx_next;
  logic [7:0]             shift_reg, shift_next;
  logic [TW-1:0]          tmo_cnt_reg, tmo_cnt_next;
  logic                   parity_ok;
  logic                   push;
  logic                   err_set;

  logic                   frame_err_reg;
  logic                   overflow_reg;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
  assign data_s = data_sync_reg[SYNC_STAGES-1];

  // Filtered clock follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
      edge_reg     <= 1'b0;
    end else begin
      edge_reg <= 1'b0;
      if (clk_s == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        filt_reg     <= clk_s;
        filt_cnt_reg <= '0;
        edge_reg     <= filt_reg;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + FW'(1);
      end
    end
  end

`ifdef PS2_RX_PARITY_CHECK_EN
  logic parity_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      parity_reg <= 1'b0;
    end else if (edge_reg && (state_reg == PARITY)) begin
      parity_reg <= data_s;
    end
  end

  assign parity_ok = ps2_odd_parity_ok(shift_reg, parity_reg);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tmo_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tmo_cnt_next = tmo_cnt_reg;
    push         = 1'b0;
    err_set      = 1'b0;
    if (state_reg == IDLE) begin
      tmo_cnt_next = '0;
      if (edge_reg) begin
        if (!data_s) begin
          state_next   = DATA;
          bit_idx_next = '0;
          shift_next   = '0;
        end else begin
          err_set = 1'b1;
        end
      end
    end else if (edge_reg) begin
      tmo_cnt_next = '0;
      case (state_reg)
        DATA: begin
          shift_next[bit_idx_reg] = data_s;
          if (bit_idx_reg == 3'(PS2_DATA_BITS - 1)) begin
            state_next = PARITY;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
        PARITY: state_next = STOP;
        STOP: begin
          if (data_s && parity_ok) begin
            push = 1'b1;
          end else begin
            err_set = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
      // Device stopped clocking mid-frame: abandon the partial byte
      state_next   = IDLE;
      tmo_cnt_next = '0;
      shift_next   = '0;
      err_set      = 1'b1;
    end else begin
      tmo_cnt_next = tmo_cnt_reg + TW'(1);
    end
  end

  assign pop = data_valid && data_ready;

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (shift_reg),
    .pop       (pop),
    .head      (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign data_valid = !fifo_empty;

  // Sticky flags: a new event wins over a clear in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (err_set) begin
        frame_err_reg <= 1'b1;
      end else if (err_clr) begin
        frame_err_reg <= 1'b0;
      end
      if (push && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end else if (err_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed plus randomized bench for ps2_rx_fifo; expected bytes come from a frame-level model.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int FIFO_DEPTH     = 8;
  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       data_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       frame_err;

  typedef logic [7:0] byte_q_t[$];

  int      checks = 0;
  int      failures = 0;
  byte_q_t got;
  int      valid_cycles = 0;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  always #5 clock = ~clock;

  // Record every accepted byte and every cycle a byte is offered
  always @(negedge clock) begin
    if (!reset) begin
      if (data_valid) valid_cycles++;
      if (data_valid && data_ready) got.push_back(data_out);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int base, input byte_q_t exp);
    chk({tag, "_len"}, 32'(got.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < got.size())
        chk($sformatf("%s[%0d]", tag, i), 32'(got[base + i]), 32'(exp[i]));
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic par_flip,
                                             input logic stop);
    return {stop, (~^b) ^ par_flip, b, 1'b0};
  endfunction

  // Drive the first nbits of a frame; optional short low glitch during one bit's high phase
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit,
                           input bit rand_ready);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        tick(10);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(HALF - 12);
      end else begin
        tick(HALF);
      end
      if (rand_ready) data_ready = 1'($urandom_range(0, 1));
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    tick(HALF);
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame_bits(b, 1'b0, 1'b1), 11, -1, 1'b0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    int      base;
    int      v0;
    byte_q_t exp_q;
    logic [10:0] bits;

    // Reset state
    tick(5);
    reset = 1'b0;
    tick(1);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_frame_err", 32'(frame_err), 0);

    // Two good bytes streamed with ready held high
    data_ready = 1'b1;
    base = got.size();
    v0 = valid_cycles;
    send_byte(8'h1C);
    send_byte(8'hF0);
    tick(5);
    chk_q("t1_bytes", base, '{8'h1C, 8'hF0});
    chk("t1_valid_cycles", 32'(valid_cycles - v0), 2);
    chk("t1_frame_err", 32'(frame_err), 0);

    // Fill past capacity, then drain at one byte per cycle
    data_ready = 1'b0;
    for (int b = 1; b <= 9; b++) send_byte(8'(b));
    chk("t2_count_full", 32'(fifo_count), FIFO_DEPTH);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_head", 32'(data_out), 32'h01);
    base = got.size();
    v0 = valid_cycles;
    data_ready = 1'b1;
    tick(20);
    chk_q("t2_drain", base, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
    chk("t2_drain_cycles", 32'(valid_cycles - v0), 8);
    chk("t2_empty", 32'(data_valid), 0);
    chk("t2_overflow_sticky", 32'(overflow), 1);
    pulse_clr();
    chk("t2_overflow_clr", 32'(overflow), 0);

    // Frame 0x1C with its parity bit inverted
    base = got.size();
    send_bits(frame_bits(8'h1C, 1'b1, 1'b1), 11, -1, 1'b0);
    tick(5);
`ifdef PS2_RX_PARITY_CHECK_EN
    chk("t3_parity_err", 32'(frame_err), 1);
    chk_q("t3_bytes", base, '{});
`else
    chk("t3_parity_err", 32'(frame_err), 0);
    chk_q("t3_bytes", base, '{8'h1C});
`endif
    pulse_clr();
    chk("t3_err_clr", 32'(frame_err), 0);

    // Device stalls after five data bits
    send_bits(frame_bits(8'h33, 1'b0, 1'b1), 6, -1, 1'b0);
    tick(TIMEOUT_CYCLES - 500);
    chk("t4_no_early_timeout", 32'(frame_err), 0);
    chk("t4_state_busy", 32'(dut.state_reg), 32'(DATA));
    tick(500);
    chk("t4_timeout_err", 32'(frame_err), 1);
    chk("t4_state_idle", 32'(dut.state_reg), 32'(IDLE));
    pulse_clr();
    base = got.size();
    send_byte(8'h5A);
    chk_q("t4_after", base, '{8'h5A});
    chk("t4_frame_err", 32'(frame_err), 0);

    // Short low glitch on ps2_clk inside bit 4
    base = got.size();
    send_bits(frame_bits(8'h1C, 1'b0, 1'b1), 11, 4, 1'b0);
    chk_q("t5_glitch", base, '{8'h1C});
    chk("t5_frame_err", 32'(frame_err), 0);

    // Bad start bit, a queued byte and a partial frame, all wiped by reset
    data_ready = 1'b0;
    send_byte(8'h77);
    chk("t6_count_pre", 32'(fifo_count), 1);
    bits = 11'h7FF;
    send_bits(bits, 1, -1, 1'b0);
    chk("t6_bad_start", 32'(frame_err), 1);
    chk("t6_count_kept", 32'(fifo_count), 1);
    send_bits(frame_bits(8'hAA, 1'b0, 1'b1), 5, -1, 1'b0);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("t6_count_rst", 32'(fifo_count), 0);
    chk("t6_valid_rst", 32'(data_valid), 0);
    data_ready = 1'b1;
    base = got.size();
    send_byte(8'h29);
    tick(5);
    chk_q("t6_after", base, '{8'h29});
    chk("t6_frame_err", 32'(frame_err), 0);
    chk("t6_overflow", 32'(overflow), 0);

    // Random bytes with random parity/stop faults and a random consumer
    base = got.size();
    exp_q = {};
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      int         kind;
      logic       good;
      b    = 8'($urandom);
      kind = $urandom_range(0, 3);
`ifdef PS2_RX_PARITY_CHECK_EN
      good = (kind != 1) && (kind != 0);
`else
      good = (kind != 1);
`endif
      send_bits(frame_bits(b, kind == 0, kind != 1), 11, -1, 1'b1);
      if (good) exp_q.push_back(b);
      chk($sformatf("rnd_err[%0d]", n), 32'(frame_err), 32'(!good));
      pulse_clr();
    end
    data_ready = 1'b1;
    tick(20);
    chk_q("rnd_bytes", base, exp_q);
    chk("rnd_overflow", 32'(overflow), 0);
    chk("rnd_empty", 32'(fifo_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver. It synchronises and deglitches the raw `ps2_clk`/`ps2_data` pins and decodes 11-bit frames: start, 8 data bits LSB first, odd parity, stop. Good bytes are buffered in a first-word-fall-through FIFO behind a valid/ready stream port. It sits between the board PS/2 pins and the keyboard MMIO device, which drains scan codes (multi-byte sequences such as F0 1C) at its own pace.

## Interface
- `FIFO_DEPTH`, 8: byte entries in the FIFO; power of two, ≥2.
- `SYNC_STAGES`, 2: flip-flop stages on each pin input; ≥2.
- `FILTER_LEN`, 4: consecutive identical synchronised samples required before the filtered `ps2_clk` changes; ≥1.
- `TIMEOUT_CYCLES`, 50000: maximum `clock` cycles between filtered falling edges inside a frame.
- `clock`  in  1  system clock; the only clock. All logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `data_out`  out  8  byte at the FIFO head; valid only while `data_valid` is high.
- `data_valid`  out  1  FIFO not empty.
- `data_ready`  in  1  consumer accepts `data_out` this cycle.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes held.
- `overflow`  out  1  sticky: a good byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a frame was aborted (bad start, parity, stop or timeout).
- `err_clr`  in  1  one-cycle pulse that clears `overflow` and `frame_err`.

## Operation
- Pin path: `SYNC_STAGES` synchroniser, then the `FILTER_LEN` stability filter on the clock line. `ps2_data` is synchronised only.
- Edge pulse: one cycle wide, asserted when the filtered clock goes from 1 to 0. Data is sampled from the synchronised `ps2_data` in the edge cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge, data 0 → DATA with bit index 0. Data 1 → stay in IDLE and set `frame_err`.
  - DATA: shift the bit into position [index]. After bit 7 → PARITY.
  - PARITY: latch the parity bit → STOP.
  - STOP: on an edge, the frame is good if data = 1 and the parity check passes. A good frame pushes the byte; otherwise set `frame_err`. → IDLE.
- Timeout: a counter runs in every state except IDLE. It clears on each edge. When it reaches `TIMEOUT_CYCLES - 1`: → IDLE, discard the partial byte, set `frame_err`.
- FIFO pop: occurs when `data_valid && data_ready`.
- Push while full: the byte is dropped and `overflow` is set. If a pop happens in the same cycle, the push is accepted and `overflow` is not set.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance. Pointers wrap modulo `FIFO_DEPTH`.
- Sticky flags: if `err_clr` arrives in the same cycle as a new error, set wins.
- Reset values: all outputs 0 (`data_out` 0x00, `fifo_count` 0). FSM in IDLE, pointers 0, filter state 1, synchronisers 1. A reset mid-frame discards the frame.

## Timing
- A pin falling edge produces the edge pulse `SYNC_STAGES + FILTER_LEN` cycles later. A pulse on `ps2_clk` shorter than `FILTER_LEN` cycles is ignored.
- The stop-bit edge in cycle N writes the FIFO at the end of N. In cycle N+1, `data_valid` = 1 and `fifo_count` is incremented.
- A pop in cycle M presents the next byte (or drops `data_valid`) in M+1. Throughput is one byte per cycle.
- `frame_err` and `overflow` rise the cycle after the causing event.

## Configuration
- `PS2_RX_PARITY_CHECK_EN` defined: a frame passes only if its 9 bits (data + parity) contain an odd number of ones; a failure sets `frame_err` and the byte is dropped.
- Undefined: the parity bit is consumed but ignored, and any frame with start 0 and stop 1 is pushed.

## Structure
- Package `ps2_pkg`:
  - state enum `ps2_rx_state_t` (IDLE, DATA, PARITY, STOP);
  - `PS2_DATA_BITS` = 8;
  - `PS2_BREAK_CODE` = 8'hF0 and `PS2_EXT_CODE` = 8'hE0, for downstream users.
- Sub-module `ps2_byte_fifo`: parametrised FWFT FIFO with push, pop, full, empty and count. The top holds the synchroniser, filter, FSM and flags.

## Test plan
- Frame 0x1C (parity 0) then 0xF0 (parity 1), `data_ready` = 1 → `data_out` shows 0x1C then 0xF0, each for one valid cycle; `frame_err` = 0.
- `FIFO_DEPTH` = 8, `data_ready` = 0, send bytes 0x01..0x09 → `fifo_count` = 8 and `overflow` = 1. Then raise `data_ready` → pops 0x01..0x08 in order; 0x09 never appears.
- With the macro defined, frame 0x1C with parity bit 1 → no push, `frame_err` = 1. Pulse `err_clr` → `frame_err` = 0. Without the macro, the same frame pushes 0x1C.
- Stop clocking after 5 data bits for `TIMEOUT_CYCLES` → `frame_err` = 1 and the FSM is in IDLE. The following good frame 0x5A is received intact.
- A 2-cycle low glitch on `ps2_clk` (`FILTER_LEN` = 4) in mid-frame → no extra bit; byte 0x1C is still received correctly.
- Assert `reset` after the 4th data bit, then send 0x29 → FIFO is empty after reset; only 0x29 is delivered, and both flags read 0.
